// File: rtl/cwait_merge_n_if.sv
// Handshake bundle for the N-channel wait-merge: producer tokens, per-channel data and
// enable mask in; merged token, merged data, free and overrun pulses out.
interface cwait_merge_n_if #(
  parameter int CHANNELS   = 3,
  parameter int DATA_WIDTH = 4
);
  logic [CHANNELS-1:0]            i_drive;
  logic [CHANNELS*DATA_WIDTH-1:0] i_data;
  logic [CHANNELS-1:0]            i_en_mask;
  logic                           i_freeNext;
  logic                           o_driveNext;
  logic [CHANNELS*DATA_WIDTH-1:0] o_data;
  logic [CHANNELS-1:0]            o_free;
  logic [CHANNELS-1:0]            o_overrun;
  logic                           o_busy;

  // Environment side: producers and downstream consumer.
  modport master (
    output i_drive, i_data, i_en_mask, i_freeNext,
    input  o_driveNext, o_data, o_free, o_overrun, o_busy
  );

  // Merge block side.
  modport slave (
    input  i_drive, i_data, i_en_mask, i_freeNext,
    output o_driveNext, o_data, o_free, o_overrun, o_busy
  );
endinterface

// File: rtl/cwait_merge_n.sv
// N-channel clocked wait-merge: buffers one token per enabled channel, emits a merged
// token with the joined data, then returns free pulses once downstream releases it.
module cwait_merge_n #(
  parameter int CHANNELS   = 3,
  parameter int DATA_WIDTH = 4
) (
  input logic            clk,
  input logic            rst,
  cwait_merge_n_if.slave bus
);
  localparam logic [1:0] ST_COLLECT   = 2'd0;
  localparam logic [1:0] ST_SEND      = 2'd1;
  localparam logic [1:0] ST_WAIT_FREE = 2'd2;

  logic [1:0]                     state_reg;
  logic [1:0]                     state_next;
  logic [CHANNELS-1:0]            arrived_reg;
  logic [CHANNELS-1:0]            arrived_next;
  logic [CHANNELS-1:0]            free_reg;
  logic [CHANNELS-1:0]            overrun_reg;
  logic [CHANNELS-1:0]            capture;
  logic [CHANNELS-1:0]            overrun_next;
  logic [DATA_WIDTH-1:0]          slot_reg   [CHANNELS];
  logic [DATA_WIDTH-1:0]          merged_reg [CHANNELS];
  logic [CHANNELS*DATA_WIDTH-1:0] merged_packed;
  logic                           in_collect;
  logic                           join_now;
  logic                           release_now;

  assign in_collect  = (state_reg == ST_COLLECT);
  // Masked-off channels count as present; an all-zero mask never joins.
  assign join_now    = in_collect && (bus.i_en_mask != '0) &&
                       (&(arrived_reg | ~bus.i_en_mask));
  assign release_now = !in_collect && bus.i_freeNext;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_COLLECT:   if (join_now) state_next = ST_SEND;
      ST_SEND:      state_next = bus.i_freeNext ? ST_COLLECT : ST_WAIT_FREE;
      ST_WAIT_FREE: if (bus.i_freeNext) state_next = ST_COLLECT;
      default:      state_next = ST_COLLECT;
    endcase
  end

  assign arrived_next = release_now ? '0 : (arrived_reg | capture);

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign capture[gi] = in_collect && bus.i_drive[gi] &&
                           bus.i_en_mask[gi] && !arrived_reg[gi];
      // Any token outside COLLECT, or a second token before release, is rejected.
      assign overrun_next[gi] = bus.i_drive[gi] && (!in_collect || arrived_reg[gi]);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          slot_reg[gi] <= '0;
        end else if (capture[gi]) begin
          slot_reg[gi] <= bus.i_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
      end

      // Merged output snapshots the slots at the join, so later captures cannot disturb it.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          merged_reg[gi] <= '0;
        end else if (join_now) begin
          merged_reg[gi] <= bus.i_en_mask[gi] ? slot_reg[gi] : '0;
        end
      end
    end
  endgenerate

  always_comb begin
    merged_packed = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      merged_packed[k*DATA_WIDTH +: DATA_WIDTH] = merged_reg[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_COLLECT;
      arrived_reg <= '0;
      free_reg    <= '0;
      overrun_reg <= '0;
    end else begin
      state_reg   <= state_next;
      arrived_reg <= arrived_next;
      free_reg    <= release_now ? arrived_reg : '0;
      overrun_reg <= overrun_next;
    end
  end

  assign bus.o_driveNext = (state_reg == ST_SEND);
  assign bus.o_busy      = !in_collect;
  assign bus.o_data      = merged_packed;
  assign bus.o_free      = free_reg;
  assign bus.o_overrun   = overrun_reg;
endmodule

// File: doc/cwait_merge_n.md
# cwait_merge_n

Clocked, parametrised N-channel wait-merge (join) for the async-control pipeline library. It collects one token per participating input channel, captures each channel's data, and emits a single merged token downstream once every enabled channel has arrived. It then holds the merged data until downstream frees it, and returns a free pulse to each contributing producer. Unlike the fixed 3-input combinational wait-merge, it buffers per-channel data, supports a runtime channel-enable mask, and flags overruns. It sits at fan-in points where several pipeline branches must rendezvous before the next stage.

## Interface
- CHANNELS, 3, number of input channels (≥2)
- DATA_WIDTH, 4, data bits per channel
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- i_drive  in  CHANNELS  per-channel one-cycle token pulse
- i_data  in  CHANNELS*DATA_WIDTH  channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]; valid in the i_drive[k] cycle
- i_en_mask  in  CHANNELS  participating channels; evaluated in COLLECT, latched at join
- i_freeNext  in  1  downstream free pulse
- o_driveNext  out  1  one-cycle merged-token pulse
- o_data  out  CHANNELS*DATA_WIDTH  merged data, same packing as i_data; channel 0 in the LSBs
- o_free  out  CHANNELS  per-channel one-cycle free pulse to producers
- o_overrun  out  CHANNELS  one-cycle pulse: token on that channel rejected
- o_busy  out  1  high when state ≠ COLLECT

## Operation
- Reset, asynchronous on rst=1, puts the block in this state:
  - state = COLLECT; arrived = 0; slots = 0; join mask = 0.
  - o_driveNext, o_free, o_overrun = 0; o_data = 0; o_busy = 0.
- State machine (Moore):
  - COLLECT → SEND when i_en_mask ≠ 0 and (arrived | ~i_en_mask) is all-ones. The join mask is latched as i_en_mask in the same edge.
  - SEND → COLLECT if i_freeNext=1 in the SEND cycle; otherwise SEND → WAIT_FREE.
  - WAIT_FREE → COLLECT when i_freeNext=1; otherwise hold.
- Capture, in COLLECT only:
  - i_drive[k]=1 with i_en_mask[k]=1 and arrived[k]=0: slot k ← data k, arrived[k] ← 1.
  - i_drive[k]=1 with arrived[k]=1: no capture; o_overrun[k] pulses next cycle.
  - i_drive[k]=1 with i_en_mask[k]=0 and arrived[k]=0: silently ignored. No capture, no overrun, no free.
- Drives in SEND or WAIT_FREE on any channel are rejected, and each raises o_overrun[k] the next cycle.
- o_data = slot k where the join mask bit k = 1, and zero where it is 0. o_data is registered at the join edge and held stable until the next join. It is not cleared by free.
- Free, on the edge that leaves SEND or WAIT_FREE via i_freeNext:
  - o_free ← arrived, so every captured channel is released, including channels captured then unmasked. Their data is zeroed in o_data.
  - arrived ← 0.
  - o_free is high for exactly one cycle.
- i_freeNext in COLLECT is ignored.
- i_en_mask = 0: the block never joins. Captures on enabled channels still accumulate.
- Mask changes after the join edge have no effect until the next COLLECT evaluation.
- Reset mid-operation drops all captured tokens and any pending free. Producers are not freed. Outputs return to their reset values immediately.

## Timing
- Last required i_drive sampled at edge E0:
  - join detected in cycle 1;
  - o_driveNext high in cycle 2 only. Latency = 2 cycles.
- Drives on different channels in the same cycle are all captured. Join requires no ordering.
- i_freeNext sampled at edge Ef:
  - o_free high in cycle Ef+1;
  - state is COLLECT in that cycle, and drives in that cycle are accepted.
- i_drive[k] in the same cycle as i_freeNext is still rejected as overrun, because the state is not yet COLLECT.
- Throughput: minimum 3 cycles per merge (drive, detect, SEND with same-cycle free).

## Test plan
- CHANNELS=3, DATA_WIDTH=4, mask=111: drives ch0=0x1 (cycle 0), ch2=0x3 (cycle 2), ch1=0x2 (cycle 4) → o_driveNext only in cycle 6, o_data=0x321. Free in cycle 8 → o_free=111 in cycle 9 only, o_busy=0 in cycle 9.
- Simultaneous drives on all three channels in cycle 0 with data A,B,C → o_driveNext in cycle 2, o_data=0xCBA. i_freeNext in cycle 2 (SEND) → o_free=111 in cycle 3.
- mask=101: drives ch0=0x5 and ch2=0x7; ch1 driven 0xF → ch1 ignored; o_data=0x705; o_free=101.
- Second drive on ch0 before join, and a drive on ch1 during WAIT_FREE → o_overrun=001 then 010, each for one cycle. Captured data unchanged.
- rst asserted in WAIT_FREE → all outputs 0 immediately. Next full join behaves as the first scenario.
- mask=000 with drives on all channels → no o_driveNext for 20 cycles. Setting mask=111 → o_driveNext 2 cycles later.
